gate_truth_table_engine: RTL and testbench
==========================================

Name: gate_truth_table_engine

Overview:
Parametrised, self-sequencing truth-table generator for N-input logic gates. On a start pulse it latches a gate mode, then sweeps every input vector 0..2^N_IN-1. Each vector is streamed with its gate output over a valid/ready interface. It is the synthesizable successor to the hand-written two-input gate truth-table benches and feeds on-chip self-test and result loggers.

Parameters:
N_IN, 2, number of gate inputs (legal 2..8); vector width and sweep length 2^N_IN.
MODE_W, 3, width of mode select.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  one-cycle request to begin a sweep; sampled only in IDLE
mode  input  MODE_W  gate function, latched on accepted start
busy  output  1  high from accepted start until done
out_valid  output  1  out_vec/out_y hold a valid beat
out_ready  input  1  downstream accepts beat when out_valid & out_ready
out_vec  output  N_IN  current input vector, LSB = input 0
out_y  output  1  gate result for out_vec under latched mode
done  output  1  one-cycle pulse after last beat accepted
cfg_err  output  1  one-cycle pulse when start arrives with reserved mode

Behaviour:
- Interface: one clock (clk); synchronous active-low reset rst_n. All outputs registered.
- Reset values: busy=0, out_valid=0, out_vec=0, out_y=0, done=0, cfg_err=0, FSM=IDLE, latched mode=0.
- Modes: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR (odd parity), 5 XNOR; 6,7 reserved.
- FSM IDLE: start & legal mode -> RUN. Next cycle busy=1, out_valid=1, out_vec=0, out_y=f(0). Latency is one cycle.
- IDLE: start & reserved mode -> stay IDLE; cfg_err=1 for one cycle.
- RUN: on accept with out_vec != all-ones, out_vec increments and out_y is recomputed in the same edge. out_valid stays 1, giving full throughput of 1 beat/cycle when out_ready=1.
- RUN: out_valid & !out_ready holds out_vec/out_y stable; no vector is skipped or repeated.
- RUN: accept of vector 2^N_IN-1 -> DONE. Next cycle out_valid=0, busy=0, done=1. DONE -> IDLE unconditionally after one cycle.
- start and mode are ignored while busy or in DONE.
- Counter is N_IN+0 bits; the final vector is detected by compare to all-ones, so there is no wrap-around into a second sweep.
- rst_n low at any time, including mid-sweep with a beat pending: the next edge forces the reset values and the pending beat is dropped.
- out_valid never drops without an accept except on reset.

Optional Feature:
Macro TT_CHECK_EN.
- Defined: adds input dut_y (1 bit, sampled on each accept) and output mismatch_cnt (N_IN+1 bits). mismatch_cnt increments when dut_y != out_y, clears on accepted start and on reset, and holds its value after done.
- Undefined: neither port exists and there is no compare logic.

Decomposition:
- Package gate_tt_pkg holds the mode localparams (GATE_AND..GATE_XNOR), MODE_W, and the FSM state encoding (IDLE, RUN, DONE).
- One sub-module, gate_eval: purely combinational N_IN-input reduction (vec, mode -> y), instantiated once.

Test Plan:
- N_IN=2, mode=2 (NAND), out_ready=1, start pulse -> beats 00/1, 01/1, 10/1, 11/0 on consecutive cycles; done one cycle after beat 11; busy low with done.
- N_IN=2, NAND, out_ready low 3 cycles while out_vec=01 -> out_vec=01 and out_y=1 stable for all 3 cycles; then 10, 11 follow; exactly 4 accepts total.
- N_IN=3, mode=4 (XOR) -> 8 beats, out_y = 0,1,1,0,1,0,0,1. start and mode=0 pulsed mid-run are ignored and the sequence is unchanged.
- rst_n low for 1 cycle while out_vec=10 -> next cycle out_valid=0, busy=0. A new start restarts the sweep at vector 0.
- start with mode=6 -> cfg_err=1 for one cycle, busy stays 0, no beats produced.
- TT_CHECK_EN, N_IN=2, NAND, dut_y driven as AND output -> mismatch_cnt=4 at done. A second run with dut_y matching -> mismatch_cnt=0.

Source files
------------

// File: rtl/gate_tt_pkg.sv
// Shared definitions for the gate truth-table engine: gate mode codes,
// default mode width and the sweep FSM state encoding.
package gate_tt_pkg;

  localparam int MODE_W = 3;

  localparam int GATE_AND  = 0;
  localparam int GATE_OR   = 1;
  localparam int GATE_NAND = 2;
  localparam int GATE_NOR  = 3;
  localparam int GATE_XOR  = 4;
  localparam int GATE_XNOR = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Codes above GATE_XNOR are reserved and rejected at start.
  function automatic logic mode_legal(input int m);
    return (m >= GATE_AND) && (m <= GATE_XNOR);
  endfunction

endpackage

// File: rtl/gate_eval.sv
// Combinational N_IN-input gate reduction: applies the selected gate
// function to vec. Reserved modes evaluate to 0.
module gate_eval
  import gate_tt_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int MODE_W = 3
) (
  input  logic [N_IN-1:0]   vec,
  input  logic [MODE_W-1:0] mode,
  output logic              y
);

  always_comb begin
    y = 1'b0;
    case (int'(mode))
      GATE_AND:  y = &vec;
      GATE_OR:   y = |vec;
      GATE_NAND: y = ~&vec;
      GATE_NOR:  y = ~|vec;
      GATE_XOR:  y = ^vec;
      GATE_XNOR: y = ~^vec;
      default:   y = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_truth_table_engine.sv
// Self-sequencing truth-table sweep over all 2^N_IN input vectors,
// streamed over valid/ready. Optional dut_y compare under TT_CHECK_EN.
module gate_truth_table_engine #(
  parameter int N_IN   = 2,
  parameter int MODE_W = gate_tt_pkg::MODE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [MODE_W-1:0] mode,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_IN-1:0]   out_vec,
  output logic              out_y,
  output logic              done,
  output logic              cfg_err
`ifdef TT_CHECK_EN
  ,
  input  logic              dut_y,
  output logic [N_IN:0]     mismatch_cnt
`endif
);
  import gate_tt_pkg::*;

  state_t              state, state_nxt;
  logic [MODE_W-1:0]   mode_q, mode_nxt;
  logic [N_IN-1:0]     vec_nxt;
  logic                busy_nxt, valid_nxt, done_nxt, err_nxt;
  logic                load_y, eval_y, accept, last_vec, start_ok;

  assign accept   = out_valid & out_ready;
  assign last_vec = (out_vec == '1);

  // Evaluate the gate on the vector being loaded, so out_y is registered
  // alongside out_vec in the same edge.
  gate_eval #(.N_IN(N_IN), .MODE_W(MODE_W)) u_eval (
    .vec  (vec_nxt),
    .mode (mode_nxt),
    .y    (eval_y)
  );

  always_comb begin
    state_nxt = state;
    mode_nxt  = mode_q;
    vec_nxt   = out_vec;
    busy_nxt  = busy;
    valid_nxt = out_valid;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    load_y    = 1'b0;
    start_ok  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (mode_legal(int'(mode))) begin
            state_nxt = RUN;
            mode_nxt  = mode;
            vec_nxt   = '0;
            load_y    = 1'b1;
            busy_nxt  = 1'b1;
            valid_nxt = 1'b1;
            start_ok  = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (accept) begin
          if (last_vec) begin
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            valid_nxt = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            vec_nxt = out_vec + N_IN'(1);
            load_y  = 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= '0;
      out_vec   <= '0;
      out_y     <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      mode_q    <= mode_nxt;
      out_vec   <= vec_nxt;
      busy      <= busy_nxt;
      out_valid <= valid_nxt;
      done      <= done_nxt;
      cfg_err   <= err_nxt;
      if (load_y) out_y <= eval_y;
    end
  end

`ifdef TT_CHECK_EN
  // Counter is N_IN+1 bits so a full-sweep mismatch (2^N_IN) never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mismatch_cnt <= '0;
    end else if (start_ok) begin
      mismatch_cnt <= '0;
    end else if (accept && (dut_y != out_y)) begin
      mismatch_cnt <= mismatch_cnt + (N_IN+1)'(1);
    end
  end
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_gate_truth_table_engine.sv
// Bench: two engines (N_IN=2 and N_IN=3) checked every cycle against a
// phase-level reference model, plus literal beat sequences.
module tb_gate_truth_table_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start0, start1, rdy0, rdy1;
  logic [2:0] mode0, mode1;
  logic       busy0, busy1, valid0, valid1, yo0, yo1, done0, done1, err0, err1;
  logic [1:0] vec0;
  logic [2:0] vec1;

`ifdef TT_CHECK_EN
  logic       dut_y0, dut_y1, dy_rnd0, dy_rnd1;
  int         dy_sel0;
  logic [2:0] mis0;
  logic [3:0] mis1;
  always_comb begin
    dut_y0 = dy_rnd0;
    if (dy_sel0 == 1) dut_y0 = &vec0;
    else if (dy_sel0 == 2) dut_y0 = ~&vec0;
    dut_y1 = dy_rnd1;
  end
`endif

  gate_truth_table_engine #(.N_IN(2), .MODE_W(3)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .mode(mode0), .busy(busy0),
    .out_valid(valid0), .out_ready(rdy0), .out_vec(vec0), .out_y(yo0),
    .done(done0), .cfg_err(err0)
`ifdef TT_CHECK_EN
    , .dut_y(dut_y0), .mismatch_cnt(mis0)
`endif
  );

  gate_truth_table_engine #(.N_IN(3), .MODE_W(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1), .busy(busy1),
    .out_valid(valid1), .out_ready(rdy1), .out_vec(vec1), .out_y(yo1),
    .done(done1), .cfg_err(err1)
`ifdef TT_CHECK_EN
    , .dut_y(dut_y1), .mismatch_cnt(mis1)
`endif
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Gate value from the mode table, using counts rather than reductions.
  function automatic int gate_f(input int md, input int v, input int n);
    int ones, all;
    ones = $countones(v);
    all  = (1 << n) - 1;
    case (md)
      0: return int'(v == all);
      1: return int'(v != 0);
      2: return int'(v != all);
      3: return int'(v == 0);
      4: return ones % 2;
      5: return 1 - (ones % 2);
      default: return 0;
    endcase
  endfunction

  // Reference model: phase 0 idle, 1 streaming, 2 done pulse.
  int m_phase[2], m_vec[2], m_mode[2], m_err[2], m_mis[2];
  int nbits[2] = '{2, 3};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int s, md, r, dy;
      s  = (i == 0) ? int'(start0) : int'(start1);
      md = (i == 0) ? int'(mode0) : int'(mode1);
      r  = (i == 0) ? int'(rdy0) : int'(rdy1);
      dy = 0;
`ifdef TT_CHECK_EN
      dy = (i == 0) ? int'(dut_y0) : int'(dut_y1);
`endif
      if (!rst_n) begin
        m_phase[i] = 0; m_vec[i] = 0; m_mode[i] = 0; m_err[i] = 0; m_mis[i] = 0;
      end else begin
        m_err[i] = 0;
        case (m_phase[i])
          0: if (s != 0) begin
               if (md <= 5) begin
                 m_phase[i] = 1; m_vec[i] = 0; m_mode[i] = md; m_mis[i] = 0;
               end else m_err[i] = 1;
             end
          1: if (r != 0) begin
               if (dy != gate_f(m_mode[i], m_vec[i], nbits[i])) m_mis[i]++;
               if (m_vec[i] == (1 << nbits[i]) - 1) m_phase[i] = 2;
               else m_vec[i]++;
             end
          default: m_phase[i] = 0;
        endcase
      end
    end
  end

  // Accepted beats as vec*2+y, for literal sequence checks.
  int q0[$], q1[$];
  always @(posedge clk) begin
    if (rst_n) begin
      if (valid0 && rdy0) q0.push_back(int'(vec0) * 2 + int'(yo0));
      if (valid1 && rdy1) q1.push_back(int'(vec1) * 2 + int'(yo1));
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        int v, b, d, e, vc, y;
        v  = (i == 0) ? int'(valid0) : int'(valid1);
        b  = (i == 0) ? int'(busy0)  : int'(busy1);
        d  = (i == 0) ? int'(done0)  : int'(done1);
        e  = (i == 0) ? int'(err0)   : int'(err1);
        vc = (i == 0) ? int'(vec0)   : int'(vec1);
        y  = (i == 0) ? int'(yo0)    : int'(yo1);
        chk($sformatf("u%0d.out_valid", i), v, int'(m_phase[i] == 1));
        chk($sformatf("u%0d.busy", i), b, int'(m_phase[i] == 1));
        chk($sformatf("u%0d.done", i), d, int'(m_phase[i] == 2));
        chk($sformatf("u%0d.cfg_err", i), e, m_err[i]);
        if (m_phase[i] == 1) begin
          chk($sformatf("u%0d.out_vec", i), vc, m_vec[i]);
          chk($sformatf("u%0d.out_y", i), y, gate_f(m_mode[i], m_vec[i], nbits[i]));
        end
`ifdef TT_CHECK_EN
        chk($sformatf("u%0d.mismatch_cnt", i), (i == 0) ? int'(mis0) : int'(mis1), m_mis[i]);
`endif
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input int i, input int md);
    if (i == 0) begin start0 = 1'b1; mode0 = 3'(md); end
    else        begin start1 = 1'b1; mode1 = 3'(md); end
    cyc(1);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int k = 0;
    while (((i == 0) ? done0 : done1) == 1'b0 && k < budget) begin
      cyc(1);
      k++;
    end
    chk($sformatf("u%0d.done_seen", i), int'((i == 0) ? done0 : done1), 1);
  endtask

  task automatic chk_queue(input string name, input int got[$], input int exp[$]);
    chk({name, ".beats"}, got.size(), exp.size());
    for (int k = 0; k < exp.size() && k < got.size(); k++)
      chk($sformatf("%s.beat%0d", name, k), got[k], exp[k]);
  endtask

  initial begin
    int nand2[$], xor3[$], none[$];
    nand2 = '{1, 3, 5, 6};
    xor3  = '{0, 3, 5, 6, 9, 10, 12, 15};
    rst_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0; mode0 = '0; mode1 = '0; rdy0 = 1'b1; rdy1 = 1'b1;
`ifdef TT_CHECK_EN
    dy_sel0 = 0; dy_rnd0 = 1'b0; dy_rnd1 = 1'b0;
`endif
    cyc(3);
    chk("reset.out_valid", int'(valid0) + int'(valid1), 0);
    chk("reset.busy", int'(busy0) + int'(busy1), 0);
    chk("reset.out_vec", int'(vec0) + int'(vec1), 0);
    chk("reset.out_y", int'(yo0) + int'(yo1), 0);
    chk("reset.done_err", int'(done0) + int'(done1) + int'(err0) + int'(err1), 0);
    chk_on = 1'b1;
    rst_n = 1'b1;
    cyc(2);

    // NAND sweep at full throughput
    q0.delete();
    pulse_start(0, 2);
    wait_done(0, 20);
    chk("nand.busy_at_done", int'(busy0), 0);
    chk_queue("nand", q0, nand2);
    cyc(2);

    // NAND with a 3-cycle stall on vector 01
    q0.delete();
    pulse_start(0, 2);
    cyc(1);
    rdy0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stall.out_vec", int'(vec0), 1);
      chk("stall.out_y", int'(yo0), 1);
      cyc(1);
    end
    rdy0 = 1'b1;
    wait_done(0, 20);
    chk_queue("stall", q0, nand2);
    cyc(2);

    // 3-input XOR, with a start/mode pulse mid-run that must be ignored
    q1.delete();
    pulse_start(1, 4);
    cyc(2);
    pulse_start(1, 0);
    wait_done(1, 30);
    chk_queue("xor3", q1, xor3);
    cyc(2);

    // Reset mid-sweep with a beat pending, then restart
    pulse_start(0, 2);
    cyc(2);
    chk("midrst.pre_vec", int'(vec0), 2);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    chk("midrst.out_valid", int'(valid0), 0);
    chk("midrst.busy", int'(busy0), 0);
    q0.delete();
    pulse_start(0, 2);
    chk("restart.out_vec", int'(vec0), 0);
    wait_done(0, 20);
    chk_queue("restart", q0, nand2);
    cyc(2);

    // Reserved mode
    q1.delete();
    pulse_start(1, 6);
    chk("cfg.cfg_err", int'(err1), 1);
    chk("cfg.busy", int'(busy1), 0);
    cyc(4);
    chk_queue("cfg", q1, none);

`ifdef TT_CHECK_EN
    dy_sel0 = 1;
    pulse_start(0, 2);
    wait_done(0, 20);
    chk("chk.mis_and", int'(mis0), 4);
    cyc(2);
    chk("chk.mis_hold", int'(mis0), 4);
    dy_sel0 = 2;
    pulse_start(0, 2);
    wait_done(0, 20);
    chk("chk.mis_match", int'(mis0), 0);
    dy_sel0 = 0;
    cyc(2);
`endif

    // Randomized traffic on both engines with occasional resets
    for (int k = 0; k < 3000; k++) begin
      start0 = ($urandom_range(0, 7) == 0);
      start1 = ($urandom_range(0, 7) == 0);
      mode0  = 3'($urandom_range(0, 7));
      mode1  = 3'($urandom_range(0, 7));
      rdy0   = ($urandom_range(0, 3) != 0);
      rdy1   = ($urandom_range(0, 3) != 0);
      rst_n  = ($urandom_range(0, 299) != 0);
`ifdef TT_CHECK_EN
      dy_rnd0 = 1'($urandom_range(0, 1));
      dy_rnd1 = 1'($urandom_range(0, 1));
`endif
      cyc(1);
    end
    start0 = 1'b0; start1 = 1'b0; rdy0 = 1'b1; rdy1 = 1'b1; rst_n = 1'b1;
    cyc(20);
    chk("final.idle", int'(busy0) + int'(busy1), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
